rheed_crop_arbiter: RTL

RHEED_CROP_ARBITER -- requirements
Module: rheed_crop_arbiter

---
 rtl/rheed_crop_arbiter_if.sv | 29 ++
 rtl/rheed_crop_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/rheed_crop_arbiter_if.sv
// rheed_crop_arbiter_if: crop streams in, merged pixel stream out, frame control
// frame_start/frame_done/busy: frame sequencing; s_axis_*: NUM_CROPS crop sources;
// m_axis_*: merged stream, tuser = crop index, tlast = last pixel of a crop.
// slave: arbiter view; master: environment view.
interface rheed_crop_arbiter_if #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int NUM_CROPS = 5
);
  localparam int UW = NUM_CROPS > 1 ? $clog2(NUM_CROPS) : 1;
  logic frame_start;
  logic [NUM_CROPS-1:0] s_axis_tvalid;
  logic [NUM_CROPS-1:0] s_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata [NUM_CROPS];
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic m_axis_tlast;
  logic frame_done;
  logic busy;
  modport slave (
    input frame_start, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, frame_done, busy
  );
  modport master (
    output frame_start, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, frame_done, busy
  );
endinterface

// File: rtl/rheed_crop_arbiter.sv
// rheed_crop_arbiter: round-robin burst arbiter merging crop streams into one registered stream
// clk/reset: clock and synchronous active-high reset; bus: rheed_crop_arbiter_if slave view.
module rheed_crop_arbiter #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int NUM_CROPS = 5,
  parameter int OUT_ROWS = 20,
  parameter int OUT_COLS = 20,
  parameter int BURST_LEN = 8
) (
  input logic clk,
  input logic reset,
  rheed_crop_arbiter_if.slave bus
);
  localparam int CROP_PIX = OUT_ROWS * OUT_COLS;
  localparam int UW = NUM_CROPS > 1 ? $clog2(NUM_CROPS) : 1;
  localparam int CW = $clog2(CROP_PIX + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt [NUM_CROPS];
  logic [UW-1:0] r_ptr, r_grant, r_muser;
  logic [BW-1:0] r_burst;
  logic [PIXEL_BIT_WIDTH-1:0] r_mdata;
  logic r_mvalid, r_mlast, r_done, r_busy;
  logic w_slot, w_hs, w_end, w_found, w_all_full;
  logic [UW-1:0] w_pick, w_idx;
  logic [CW-1:0] w_cnt_nx;
  // the output register can take a new beat when empty or being drained this cycle
  assign w_slot = !r_mvalid || bus.m_axis_tready;
  assign w_hs = r_state == XFER && w_slot && bus.s_axis_tvalid[r_grant];
  assign w_cnt_nx = r_cnt[r_grant] + 1'b1;
  assign w_end = w_hs && (r_burst == BW'(BURST_LEN - 1) || w_cnt_nx == CW'(CROP_PIX));
  assign bus.s_axis_tready = (r_state == XFER && w_slot) ? NUM_CROPS'(1) << r_grant : '0;
  assign bus.m_axis_tvalid = r_mvalid;
  assign bus.m_axis_tdata = r_mdata;
  assign bus.m_axis_tuser = r_muser;
  assign bus.m_axis_tlast = r_mlast;
  assign bus.frame_done = r_done;
  assign bus.busy = r_busy;
  // scan downward in offset so the candidate closest to the pointer wins
  always_comb begin
    w_found = 1'b0;
    w_pick = '0;
    w_idx = '0;
    w_all_full = 1'b1;
    for (int k = NUM_CROPS - 1; k >= 0; k--) begin
      w_idx = UW'((int'(r_ptr) + k) % NUM_CROPS);
      if (r_cnt[w_idx] != CW'(CROP_PIX)) w_all_full = 1'b0;
      if (bus.s_axis_tvalid[w_idx] && r_cnt[w_idx] != CW'(CROP_PIX)) begin
        w_found = 1'b1;
        w_pick = w_idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      r_burst <= '0;
      r_mvalid <= 1'b0;
      r_mdata <= '0;
      r_muser <= '0;
      r_mlast <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      for (int c = 0; c < NUM_CROPS; c++) r_cnt[c] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_hs) begin
        r_mvalid <= 1'b1;
        r_mdata <= bus.s_axis_tdata[r_grant];
        r_muser <= r_grant;
        r_mlast <= w_cnt_nx == CW'(CROP_PIX);
        r_cnt[r_grant] <= w_cnt_nx;
        r_burst <= w_end ? '0 : r_burst + 1'b1;
      end else if (bus.m_axis_tready) begin
        r_mvalid <= 1'b0;
      end
      case (r_state)
        IDLE: if (bus.frame_start) begin
          r_state <= ARB;
          r_busy <= 1'b1;
          r_ptr <= '0;
          for (int c = 0; c < NUM_CROPS; c++) r_cnt[c] <= '0;
        end
        ARB: if (w_all_full && !r_mvalid) begin
          r_state <= DONE;
          r_done <= 1'b1;
        end else if (w_found) begin
          r_grant <= w_pick;
          r_state <= XFER;
        end
        XFER: if (w_end) begin
          r_ptr <= r_grant == UW'(NUM_CROPS - 1) ? '0 : r_grant + 1'b1;
          r_state <= ARB;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
